// File: rtl/shift_result_fifo_if.sv
// shift_result_fifo_if: handshake bundle for the shifter result FIFO.
//   in_valid/in_ready/in_data/in_ctrl : producer side (shifter result + control tag)
//   out_valid/out_ready/out_data/out_ctrl/out_zero/out_msb/out_parity : consumer side
// Modports:
//   slave  : the FIFO itself
//   master : the environment driving the producer and consumer sides
interface shift_result_fifo_if #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_zero;
  logic              out_msb;
  logic              out_parity;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_zero, out_msb, out_parity
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_zero, out_msb, out_parity
  );
endinterface

// File: rtl/shift_result_fifo.sv
// shift_result_fifo: capture FIFO behind the 16-bit shifter. Stores each result
// with its control tag and zero/msb/parity flags computed at write time, and
// presents the head entry show-ahead from registers.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : in_* push side, out_* pop side (see shift_result_fifo_if)
//   count           : occupancy 0..DEPTH
//   full, empty     : registered status
//   drop_cnt        : saturating count of words offered while full
//                     (only when SHIFT_FIFO_DROP_CNT_EN is defined)
module shift_result_fifo #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_result_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef SHIFT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [WIDTH-1:0]  data;
    logic              zero;
    logic              msb;
    logic              parity;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_ent, head, head_next;
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]   count_next;
  logic            valid_q;
  logic            push, pop;

  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = valid_q && bus.out_ready;

  always_comb begin
    in_ent.ctrl   = bus.in_ctrl;
    in_ent.data   = bus.in_data;
    in_ent.zero   = (bus.in_data == '0);
    in_ent.msb    = bus.in_data[WIDTH-1];
    in_ent.parity = ^bus.in_data;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;
    head_next = head;
    // Next head comes from storage if it is already there; otherwise it is the
    // word being written on this edge (FIFO empty, or draining its last entry).
    // With no push and nothing left, the stale head is kept so it stays stable.
    if (pop && count != CW'(1))
      head_next = mem[rd_next];
    else if ((pop || count == '0) && push)
      head_next = in_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      valid_q <= 1'b0;
      head    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_next;
      count   <= count_next;
      full    <= (count_next == CW'(DEPTH));
      empty   <= (count_next == '0);
      valid_q <= (count_next != '0);
      head    <= head_next;
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_data   = head.data;
  assign bus.out_ctrl   = head.ctrl;
  assign bus.out_zero   = head.zero;
  assign bus.out_msb    = head.msb;
  assign bus.out_parity = head.parity;

`ifdef SHIFT_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (bus.in_valid && full && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule
